fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side master for the team's 128-bit synchronous FIFO.
- Drains a programmed number of words from the FIFO and presents them downstream as a valid/ready stream, marking the last word of the burst.
- Absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so downstream back-pressure never loses or duplicates a word.
- Sits between the FIFO read port and any stream consumer (DMA, packetiser).

Parameters:
- DATA_WIDTH, 128, width of FIFO words and stream data.
- LEN_WIDTH, 16, width of the burst length field.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_start  input  1  one-cycle pulse; begins a burst when idle.
- i_len  input  LEN_WIDTH  burst length in words, sampled with i_start.
- o_busy  output  1  high from accepted start until the burst completes.
- o_done  output  1  one-cycle pulse when the burst completes.
- o_rden  output  1  FIFO read enable.
- i_rddata  input  DATA_WIDTH  FIFO read data, valid the cycle after o_rden.
- i_empty  input  1  FIFO empty flag.
- o_valid  output  1  stream data valid.
- i_ready  input  1  downstream accepts when o_valid and i_ready are both high.
- o_data  output  DATA_WIDTH  stream data (head of the output buffer).
- o_last  output  1  high with the final word of the burst.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all counters 0, buffer empty.
  - o_busy=0, o_done=0, o_rden=0, o_valid=0, o_last=0, o_data=0.
  - Reset mid-burst discards all buffered and in-flight words; the burst is not completed and o_done is not pulsed.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE: i_start=1 with i_len>0 -> load rd_remain=i_len and out_remain=i_len, go to RUN; o_busy=1 from the next cycle.
  - IDLE: i_start=1 with i_len=0 -> stay IDLE, pulse o_done the next cycle, o_busy stays 0.
  - RUN: when rd_remain reaches 0, go to FLUSH.
  - FLUSH: when out_remain reaches 0, return to IDLE, drop o_busy, and pulse o_done in that same cycle.
  - i_start is ignored outside IDLE.
- Read issue rule: o_rden=1 in a cycle only if all of the following hold:
  - state=RUN;
  - rd_remain>0;
  - i_empty=0;
  - o_rden was 0 in the previous cycle;
  - occupancy + inflight < 2, where occupancy is buffered words and inflight is 0 or 1.
- The "o_rden low in the previous cycle" condition tolerates the one-cycle-stale empty flag. Peak rate is therefore one word per 2 cycles.
- Each o_rden decrements rd_remain.
- Read capture: i_rddata is written into the buffer tail on the cycle after o_rden, unconditionally.
- Output buffer:
  - 2-entry FIFO; o_valid = occupancy>0.
  - o_data and o_last are valid only while o_valid=1.
  - A downstream handshake pops the head and decrements out_remain.
  - o_last=1 when o_valid=1 and out_remain=1.
  - A capture and a pop in the same cycle leave occupancy unchanged and keep word order.
  - Occupancy never exceeds 2, and o_data never changes while o_valid=1 and i_ready=0.
- i_empty high for any duration only stalls reads; there is no timeout.
- Counters are LEN_WIDTH bits wide and never underflow. A maximum burst of 65535 words completes normally.

Test Plan:
- Reset, then start with i_len=4 into a FIFO holding 4 words, i_ready=1 -> 4 beats with o_data in FIFO order, o_last only on beat 4, o_rden never high in 2 consecutive cycles, one o_done pulse, o_busy=0 afterwards.
- i_len=3 with i_ready held low for 10 cycles after the first o_valid -> exactly 2 o_rden pulses until the first pop, o_data stable throughout, then all 3 words delivered with no loss or duplication.
- i_len=5 with only 2 words available; third word written 20 cycles later -> reads stall while i_empty=1 and resume afterwards; o_busy stays high until the fifth beat and o_done.
- i_len=0 start -> o_done pulses next cycle, no o_rden, o_valid stays 0, o_busy stays 0.
- Reset asserted mid-burst at i_len=8 after 3 beats -> all outputs 0 immediately, no o_done; a new start with i_len=2 then completes normally.
- Second i_start with i_len=9 during a busy i_len=4 burst -> ignored; exactly 4 beats delivered.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a programmed burst from the 128-bit FIFO into a valid/ready stream,
// hiding the FIFO's registered read latency behind a 2-entry output buffer.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 128,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rden,
  input  logic [DATA_WIDTH-1:0] i_rddata,
  input  logic                  i_empty,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nx;
  logic [LEN_WIDTH-1:0] rd_remain, out_remain;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic head, tail, inflight, done_nx, start_ok, pop, flush_end;
  logic [1:0] occ;
  assign start_ok  = state == IDLE && i_start && i_len != '0;
  assign flush_end = state == FLUSH && out_remain == '0;
  assign pop       = o_valid && i_ready;
  assign o_valid   = occ != 2'd0;
  assign o_data    = buf_q[head];
  assign o_last    = o_valid && out_remain == LEN_WIDTH'(1);
  assign o_busy    = state != IDLE;
  // inflight is last cycle's o_rden, which also masks the one-cycle-stale empty flag
  assign o_rden    = state == RUN && rd_remain != '0 && !i_empty && !inflight &&
                     ({1'b0, occ} + {2'b0, inflight}) < 3'd2;
  always_comb begin
    state_nx = start_ok ? RUN :
               (state == RUN && rd_remain == '0) ? FLUSH :
               flush_end ? IDLE : state;
    done_nx  = (state == IDLE && i_start && i_len == '0) || flush_end;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      o_done     <= 1'b0;
      inflight   <= 1'b0;
      rd_remain  <= '0;
      out_remain <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
      occ        <= 2'd0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      state    <= state_nx;
      o_done   <= done_nx;
      inflight <= o_rden;
      if (start_ok) rd_remain <= i_len;
      else if (o_rden) rd_remain <= rd_remain - 1'b1;
      if (start_ok) out_remain <= i_len;
      else if (pop && out_remain != '0) out_remain <= out_remain - 1'b1;
      if (inflight) begin
        buf_q[tail] <= i_rddata;
        tail        <= ~tail;
      end
      if (pop) head <= ~head;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: directed bench with a small FIFO model feeding the reader.
module tb_fifo_burst_reader;
  localparam int DW = 128;
  localparam int LW = 16;
  logic clk = 1'b0, reset = 1'b0, i_start = 1'b0, i_ready = 1'b1;
  logic [LW-1:0] i_len = '0;
  logic [DW-1:0] i_rddata = '0, o_data;
  logic o_busy, o_done, o_rden, i_empty, o_valid, o_last;
  logic [DW-1:0] mem [0:63];
  int wp = 0, rp = 0, base;
  int checks = 0, errors = 0;
  logic [DW-1:0] beats[$];
  logic lasts[$];
  int rdens, consec, dones, unstable;
  logic prev_rden, prev_stall;
  logic [DW-1:0] prev_data;

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
    .o_done(o_done), .o_rden(o_rden), .i_rddata(i_rddata), .i_empty(i_empty),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last)
  );

  always #5 clk = ~clk;
  assign i_empty = (wp == rp);
  // FIFO model: registered read data one cycle after o_rden; flushed while reset is low
  always @(posedge clk) begin
    if (!reset) rp <= wp;
    else if (o_rden) begin
      i_rddata <= mem[rp];
      rp <= rp + 1;
    end
  end

  function automatic logic [DW-1:0] mkw(input int k);
    return {4{32'hC0DE0000 | 32'(k)}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp] = mkw(wp);
      wp++;
    end
  endtask

  task automatic clr();
    beats.delete();
    lasts.delete();
    rdens = 0; consec = 0; dones = 0; unstable = 0;
    prev_rden = 1'b0; prev_stall = 1'b0; prev_data = '0;
  endtask

  task automatic sample();
    if (o_valid && i_ready) begin
      beats.push_back(o_data);
      lasts.push_back(o_last);
    end
    if (o_rden) rdens++;
    if (o_rden && prev_rden) consec++;
    if (o_done) dones++;
    if (prev_stall && o_valid && o_data !== prev_data) unstable++;
    prev_rden  = o_rden;
    prev_stall = o_valid && !i_ready;
    prev_data  = o_data;
  endtask

  task automatic cycle();
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int stop);
    for (int i = 0; i < n; i++) begin
      if (beats.size() >= stop) break;
      cycle();
    end
  endtask

  task automatic kick(input int len);
    i_start = 1'b1;
    i_len = LW'(len);
    cycle();
    i_start = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int b, input int len);
    chk({tag, "_count"}, DW'(beats.size()), DW'(len));
    for (int k = 0; k < beats.size() && k < len; k++) begin
      chk($sformatf("%s_data%0d", tag, k), beats[k], mkw(b + k));
      chk($sformatf("%s_last%0d", tag, k), DW'(lasts[k]), DW'(k == len - 1));
    end
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", DW'(o_busy), '0);
    chk("rst_done", DW'(o_done), '0);
    chk("rst_rden", DW'(o_rden), '0);
    chk("rst_valid", DW'(o_valid), '0);
    chk("rst_last", DW'(o_last), '0);
    chk("rst_data", o_data, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    // basic burst of 4 with free-running downstream
    base = wp; push(4); clr(); kick(4); run(30, 99);
    check_beats("t1", base, 4);
    chk("t1_consec_rden", DW'(consec), '0);
    chk("t1_done", DW'(dones), DW'(1));
    chk("t1_busy_after", DW'(o_busy), '0);
    // back-pressure: buffer fills with two words, head held stable
    base = wp; push(3); i_ready = 1'b0; clr(); kick(3);
    for (int g = 0; g < 20 && !o_valid; g++) cycle();
    chk("t2_valid", DW'(o_valid), DW'(1));
    chk("t2_head", o_data, mkw(base));
    run(10, 99);
    chk("t2_rdens", DW'(rdens), DW'(2));
    chk("t2_stable", DW'(unstable), '0);
    chk("t2_nopop", DW'(beats.size()), '0);
    i_ready = 1'b1;
    run(20, 99);
    check_beats("t2", base, 3);
    chk("t2_done", DW'(dones), DW'(1));
    // FIFO runs dry mid-burst
    base = wp; push(2); clr(); kick(5); run(20, 99);
    chk("t3_stall_beats", DW'(beats.size()), DW'(2));
    chk("t3_stall_rdens", DW'(rdens), DW'(2));
    chk("t3_stall_busy", DW'(o_busy), DW'(1));
    chk("t3_stall_done", DW'(dones), '0);
    push(3); run(40, 99);
    check_beats("t3", base, 5);
    chk("t3_done", DW'(dones), DW'(1));
    chk("t3_busy_after", DW'(o_busy), '0);
    // zero-length burst
    clr(); kick(0);
    chk("t4_done_pulse", DW'(o_done), DW'(1));
    chk("t4_busy", DW'(o_busy), '0);
    run(6, 99);
    chk("t4_rdens", DW'(rdens), '0);
    chk("t4_beats", DW'(beats.size()), '0);
    chk("t4_done_once", DW'(dones), DW'(1));
    // reset mid-burst, then recover
    base = wp; push(8); clr(); kick(8); run(60, 3);
    chk("t5_three_beats", DW'(beats.size()), DW'(3));
    reset = 1'b0;
    #1;
    chk("t5_rst_busy", DW'(o_busy), '0);
    chk("t5_rst_done", DW'(o_done), '0);
    chk("t5_rst_rden", DW'(o_rden), '0);
    chk("t5_rst_valid", DW'(o_valid), '0);
    chk("t5_rst_last", DW'(o_last), '0);
    chk("t5_rst_data", o_data, '0);
    clr(); run(3, 99);
    chk("t5_rst_nodone", DW'(dones), '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    base = wp; push(2); clr(); kick(2); run(20, 99);
    check_beats("t5b", base, 2);
    chk("t5b_done", DW'(dones), DW'(1));
    // start while busy is ignored
    base = wp; push(12); clr(); kick(4); run(3, 99); kick(9); run(40, 99);
    check_beats("t6", base, 4);
    chk("t6_done", DW'(dones), DW'(1));
    chk("t6_busy_after", DW'(o_busy), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
